mil_tx_word_seq: RTL and testbench
==================================

// Module: mil_tx_word_seq
// PURPOSE
// Transmit-side word sequencer for the MIL-STD-1553 terminal. Host loads one
// command/status word plus up to DEPTH data words, then pulses start; block
// hands words one at a time to the Manchester encoder, tagging each with its
// sync type, and pulses DONE once the last word has gone out. Counterpart of
// the receive-side CW/DW capture buffer.
// PARAMETERS
// DEPTH  32  max data words per message (1553 limit)
// AW     5   data buffer address width, 2**AW >= DEPTH
// PORTS
// clk      in   1   system clock, rising edge
// R        in   1   reset, synchronous, active-high
// ce       in   1   host write strobe, one word per cycle
// DAT_IN   in   16  host word to load
// CW_DW    in   1   1 = write is command/status word, 0 = data word
// start    in   1   begin transmission of loaded message
// TX_DONE  in   1   encoder: one-cycle pulse, current word fully sent
// TX_DAT   out  16  word presented to encoder
// TX_SYNC  out  1   1 = command/status sync, 0 = data sync
// TX_STB   out  1   one-cycle load strobe to encoder
// busy     out  1   high from accepted start until DONE
// DONE     out  1   one-cycle pulse, message complete
// ERR      out  1   sticky error: buffer overflow or start without CW
// WCNT     out  AW+1  data words currently loaded
// BEHAVIOUR
// - Reset (R sampled high on clk edge): state IDLE; TX_DAT=0, TX_SYNC=0,
//   TX_STB=0, busy=0, DONE=0, ERR=0, WCNT=0, cw_valid=0, pointers=0.
//   Reset mid-message aborts immediately; buffer contents discarded.
// - All outputs registered.
// - Load (IDLE only): ce&CW_DW stores DAT_IN in CW register, sets cw_valid
//   (rewrite overwrites). ce&!CW_DW writes buffer[WCNT], WCNT+1; if WCNT==DEPTH
//   write dropped, ERR set. ce while busy ignored.
// - start in IDLE: if cw_valid -> SEND_CW, busy=1, ERR cleared; else ERR=1,
//   stay IDLE, no strobe. start while busy ignored. start and ce in the same
//   IDLE cycle: start wins, ce ignored.
// - States: IDLE, SEND_CW, WAIT_CW, SEND_DW, WAIT_DW, FINISH.
//   SEND_CW: TX_STB=1, TX_DAT=CW, TX_SYNC=1 for one cycle -> WAIT_CW.
//   WAIT_CW: on TX_DONE -> WCNT==0 ? FINISH : SEND_DW.
//   SEND_DW: TX_STB=1, TX_DAT=buffer[rd_ptr], TX_SYNC=0 -> WAIT_DW.
//   WAIT_DW: on TX_DONE rd_ptr+1; rd_ptr+1==WCNT ? FINISH : SEND_DW.
//   FINISH: DONE=1 one cycle, busy=0, WCNT/rd_ptr/cw_valid cleared -> IDLE.
// - Latency: start at edge n -> TX_STB high cycle n+1. TX_DONE at edge m ->
//   next TX_STB (or DONE) high cycle m+1. Words contiguous, no added gap.
// - TX_DONE outside WAIT_CW/WAIT_DW ignored. TX_DAT/TX_SYNC hold last value
//   between strobes.
// - WCNT is AW+1 bits so DEPTH is representable; rd_ptr never exceeds WCNT-1.
// TESTING
// 1 Load CW 0x1823, DW 0xAAAA,0x5555,0x0001; start; encoder model pulses
//   TX_DONE 20 cycles after each TX_STB -> 4 strobes, SYNC 1,0,0,0, data in
//   order, DONE 1 cycle after 4th TX_DONE, busy low, WCNT=0.
// 2 Load CW 0x0C40 only; start -> one TX_STB, SYNC=1, DONE after its TX_DONE.
// 3 Write 33 DWs -> WCNT=32, ERR=1, 33rd dropped; CW+start -> ERR clears,
//   32 DW strobes, last TX_DAT = 32nd word.
// 4 start with no CW loaded -> ERR=1, no TX_STB, busy stays 0.
// 5 R high during WAIT_DW after 2nd DW strobe -> next cycle all outputs at
//   reset values; later TX_DONE produces no strobe or DONE.
// 6 ce with CW_DW=1 while busy -> CW unchanged; in IDLE two CW writes
//   0x1111 then 0x2222 -> transmitted CW = 0x2222; start+ce same cycle ->
//   that write not stored.

Source files
------------

// File: rtl/mil_tx_word_seq.sv
// Purpose : MIL-STD-1553 transmit word sequencer; sends one CW then up to DEPTH DWs to the encoder.
// Latency : start -> first o_tx_stb next cycle; encoder i_tx_done -> next strobe or o_done next cycle.
// Backpressure : one word in flight; the next word waits for i_tx_done. Host writes are ignored while busy.
//
// Ports
//   i_clk      system clock, rising edge
//   i_r        synchronous active-high reset
//   i_ce       host write strobe, one word per cycle (IDLE only)
//   i_dat_in   host word to load
//   i_cw_dw    1 = write targets the command/status word, 0 = next data word
//   i_start    begin transmitting the loaded message
//   i_tx_done  encoder pulse: current word fully sent
//   o_tx_dat   word presented to the encoder (held between strobes)
//   o_tx_sync  1 = command/status sync, 0 = data sync
//   o_tx_stb   one-cycle load strobe to the encoder
//   o_busy     high from accepted start until o_done
//   o_done     one-cycle pulse, message complete
//   o_err      sticky: buffer overflow or start without a CW loaded
//   o_wcnt     number of data words currently loaded
module mil_tx_word_seq #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_r,
  input  logic          i_ce,
  input  logic [15:0]   i_dat_in,
  input  logic          i_cw_dw,
  input  logic          i_start,
  input  logic          i_tx_done,
  output logic [15:0]   o_tx_dat,
  output logic          o_tx_sync,
  output logic          o_tx_stb,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW:0]   o_wcnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND_CW = 3'd1;
  localparam logic [2:0] S_WAIT_CW = 3'd2;
  localparam logic [2:0] S_SEND_DW = 3'd3;
  localparam logic [2:0] S_WAIT_DW = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [2:0]    r_state;
  logic [15:0]   r_cw;
  logic          r_cw_vld;
  logic [AW:0]   r_wcnt;
  logic [AW-1:0] r_rd_ptr;
  logic [15:0]   r_tx_dat;
  logic          r_tx_sync;
  logic          r_tx_stb;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [15:0]   r_buf [0:DEPTH-1];

  logic          w_full;
  logic          w_dw_wr;
  logic [AW:0]   w_rd_nxt;

  assign w_full   = (r_wcnt == DEPTH_W);
  // start has priority over a host write in the same IDLE cycle
  assign w_dw_wr  = (r_state == S_IDLE) && i_ce && !i_cw_dw && !i_start && !w_full;
  // one bit wider than the pointer so it can be compared against a full count
  assign w_rd_nxt = {1'b0, r_rd_ptr} + 1'b1;

  // Data buffer: contents need no reset, o_wcnt says how many are valid.
  always_ff @(posedge i_clk) begin
    if (w_dw_wr) begin
      r_buf[r_wcnt[AW-1:0]] <= i_dat_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_r) begin
      r_state   <= S_IDLE;
      r_cw      <= 16'h0000;
      r_cw_vld  <= 1'b0;
      r_wcnt    <= '0;
      r_rd_ptr  <= '0;
      r_tx_dat  <= 16'h0000;
      r_tx_sync <= 1'b0;
      r_tx_stb  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_stb <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (r_cw_vld) begin
              // strobe is loaded here so it is visible in the SEND_CW cycle
              r_state   <= S_SEND_CW;
              r_busy    <= 1'b1;
              r_err     <= 1'b0;
              r_tx_stb  <= 1'b1;
              r_tx_dat  <= r_cw;
              r_tx_sync <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (i_ce) begin
            if (i_cw_dw) begin
              r_cw     <= i_dat_in;
              r_cw_vld <= 1'b1;
            end else if (w_full) begin
              r_err <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        S_SEND_CW: r_state <= S_WAIT_CW;
        S_WAIT_CW: begin
          if (i_tx_done) begin
            if (r_wcnt == '0) begin
              r_state  <= S_FINISH;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_wcnt   <= '0;
              r_rd_ptr <= '0;
              r_cw_vld <= 1'b0;
            end else begin
              r_state   <= S_SEND_DW;
              r_tx_stb  <= 1'b1;
              r_tx_dat  <= r_buf[r_rd_ptr];
              r_tx_sync <= 1'b0;
            end
          end
        end
        S_SEND_DW: r_state <= S_WAIT_DW;
        S_WAIT_DW: begin
          if (i_tx_done) begin
            if (w_rd_nxt == r_wcnt) begin
              r_state  <= S_FINISH;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_wcnt   <= '0;
              r_rd_ptr <= '0;
              r_cw_vld <= 1'b0;
            end else begin
              r_state   <= S_SEND_DW;
              r_rd_ptr  <= r_rd_ptr + 1'b1;
              r_tx_stb  <= 1'b1;
              r_tx_dat  <= r_buf[w_rd_nxt[AW-1:0]];
              r_tx_sync <= 1'b0;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_dat  = r_tx_dat;
  assign o_tx_sync = r_tx_sync;
  assign o_tx_stb  = r_tx_stb;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_wcnt    = r_wcnt;

endmodule

// File: tb/tb_mil_tx_word_seq.sv
// Purpose : randomized scoreboard bench for mil_tx_word_seq with an encoder model.
// Latency : expects each strobe/done exactly one cycle after the encoder's done pulse.
// Backpressure : encoder model answers each strobe after enc_dly cycles.
module tb_mil_tx_word_seq;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          i_r, i_ce, i_cw_dw, i_start, i_tx_done;
  logic [15:0]   i_dat_in;
  logic [15:0]   o_tx_dat;
  logic          o_tx_sync, o_tx_stb, o_busy, o_done, o_err;
  logic [AW:0]   o_wcnt;

  always #5 clk = ~clk;

  mil_tx_word_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_r(i_r), .i_ce(i_ce), .i_dat_in(i_dat_in), .i_cw_dw(i_cw_dw),
    .i_start(i_start), .i_tx_done(i_tx_done), .o_tx_dat(o_tx_dat), .o_tx_sync(o_tx_sync),
    .o_tx_stb(o_tx_stb), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_wcnt(o_wcnt)
  );

  typedef struct packed { logic sync; logic [15:0] dat; } word_t;

  int     n_chk = 0;
  int     n_pass = 0;
  word_t  exp_q[$];
  int     exp_done = 0;
  int     n_stb = 0;
  word_t  mon_w;
  int     enc_dly = 20;
  bit     lat_chk = 1'b1;

  // reference model of the host-visible message state
  logic [15:0] m_cw;
  bit          m_cw_vld = 1'b0;
  logic [15:0] m_dw[$];
  bit          m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (o_tx_stb === 1'b1) begin
      n_stb++;
      if (exp_q.size() == 0) check("unexpected_stb", 32'd1, 32'd0);
      else begin
        mon_w = exp_q.pop_front();
        check("tx_sync", 32'(o_tx_sync), 32'(mon_w.sync));
        check("tx_dat", 32'(o_tx_dat), 32'(mon_w.dat));
      end
    end
    if (o_done === 1'b1) begin
      if (exp_done == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        check("words_left_at_done", 32'(exp_q.size()), 32'd0);
        check("busy_at_done", 32'(o_busy), 32'd0);
        exp_done--;
      end
    end
  end

  // encoder model: TX_DONE enc_dly cycles after each strobe
  initial begin
    i_tx_done = 1'b0;
    forever begin
      if (o_tx_stb === 1'b1 && i_r == 1'b0) begin
        repeat (enc_dly - 1) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        if (lat_chk) check("next_after_tx_done", 32'(o_tx_stb | o_done), 32'd1);
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic wr(input bit cw, input logic [15:0] d);
    i_ce = 1'b1; i_cw_dw = cw; i_dat_in = d;
    if (cw) begin m_cw = d; m_cw_vld = 1'b1; end
    else if (m_dw.size() == DEPTH) m_err = 1'b1;
    else m_dw.push_back(d);
    @(negedge clk);
    i_ce = 1'b0; i_cw_dw = 1'b0;
  endtask

  task automatic do_start(input bit with_ce, input logic [15:0] d);
    bit ok;
    ok = m_cw_vld;
    // expectations are queued before the edge so the monitor never races them
    if (ok) begin
      exp_q.push_back('{sync: 1'b1, dat: m_cw});
      foreach (m_dw[k]) exp_q.push_back('{sync: 1'b0, dat: m_dw[k]});
      exp_done++;
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    i_start = 1'b1; i_ce = with_ce; i_cw_dw = 1'b0; i_dat_in = d;
    @(negedge clk);
    i_start = 1'b0; i_ce = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'(ok));
    check("err_after_start", 32'(o_err), 32'(m_err));
    if (ok) begin m_dw.delete(); m_cw_vld = 1'b0; end
  endtask

  task automatic wait_msg();
    int t;
    t = 0;
    while ((exp_done != 0 || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      check("msg_timeout", 32'd1, 32'd0);
      exp_q.delete();
      exp_done = 0;
    end
    repeat (2) @(negedge clk);
    check("busy_idle", 32'(o_busy), 32'd0);
    check("wcnt_idle", 32'(o_wcnt), 32'(m_dw.size()));
    check("err_idle", 32'(o_err), 32'(m_err));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_dat"}, 32'(o_tx_dat), 32'd0);
    check({tag, "_tx_sync"}, 32'(o_tx_sync), 32'd0);
    check({tag, "_tx_stb"}, 32'(o_tx_stb), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_wcnt"}, 32'(o_wcnt), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] last_dw;
    int          base;
    int          t;
    i_r = 1'b1; i_ce = 1'b0; i_cw_dw = 1'b0; i_dat_in = 16'h0; i_start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    i_r = 1'b0;

    // basic message, slow encoder
    enc_dly = 20;
    wr(1'b1, 16'h1823);
    wr(1'b0, 16'hAAAA); wr(1'b0, 16'h5555); wr(1'b0, 16'h0001);
    check("wcnt_loaded3", 32'(o_wcnt), 32'd3);
    do_start(1'b0, 16'h0);
    wait_msg();

    // command word only
    enc_dly = 5;
    wr(1'b1, 16'h0C40);
    do_start(1'b0, 16'h0);
    wait_msg();

    // overflow: 33rd word dropped
    enc_dly = 3;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH - 1) last_dw = 16'($urandom);
      wr(1'b0, (i == DEPTH - 1) ? last_dw : 16'($urandom));
    end
    check("wcnt_full", 32'(o_wcnt), 32'(DEPTH));
    check("err_overflow", 32'(o_err), 32'd1);
    wr(1'b1, 16'h4321);
    do_start(1'b0, 16'h0);
    wait_msg();
    check("last_dat_held", 32'(o_tx_dat), 32'(last_dw));

    // start without CW
    do_start(1'b0, 16'h0);
    repeat (5) @(negedge clk);
    check("nocw_busy", 32'(o_busy), 32'd0);
    check("nocw_err", 32'(o_err), 32'd1);
    check("nocw_dat_held", 32'(o_tx_dat), 32'(last_dw));

    // CW rewrite, writes while busy, start+ce collision
    enc_dly = 10;
    wr(1'b1, 16'h1111); wr(1'b1, 16'h2222);
    wr(1'b0, 16'h00A5); wr(1'b0, 16'h005A);
    do_start(1'b0, 16'h0);
    repeat (2) @(negedge clk);
    i_ce = 1'b1; i_cw_dw = 1'b1; i_dat_in = 16'hDEAD; @(negedge clk);
    i_cw_dw = 1'b0; i_dat_in = 16'hBEEF; @(negedge clk);
    i_ce = 1'b0;
    check("wcnt_busy_write", 32'(o_wcnt), 32'd2);
    wait_msg();
    wr(1'b1, 16'h3333); wr(1'b0, 16'h0001);
    do_start(1'b1, 16'h7777);
    wait_msg();

    // reset during WAIT_DW after the 2nd data-word strobe
    enc_dly = 6;
    wr(1'b1, 16'hC0DE);
    for (int i = 0; i < 4; i++) wr(1'b0, 16'($urandom));
    base = n_stb;
    do_start(1'b0, 16'h0);
    t = 0;
    while (n_stb < base + 3 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) check("reset_test_timeout", 32'd1, 32'd0);
    lat_chk = 1'b0;
    i_r = 1'b1;
    @(negedge clk);
    i_r = 1'b0;
    exp_q.delete(); exp_done = 0;
    m_dw.delete(); m_cw_vld = 1'b0; m_err = 1'b0;
    check_reset_vals("midmsg_reset");
    repeat (30) @(negedge clk);
    check("post_reset_busy", 32'(o_busy), 32'd0);
    check("post_reset_wcnt", 32'(o_wcnt), 32'd0);
    lat_chk = 1'b1;

    // randomized messages
    for (int r = 0; r < 8; r++) begin
      enc_dly = int'($urandom_range(2, 6));
      if ($urandom_range(0, 1) == 1) wr(1'b1, 16'($urandom));
      wr(1'b1, 16'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) wr(1'b0, 16'($urandom));
      check("rand_wcnt", 32'(o_wcnt), 32'(m_dw.size()));
      do_start(1'b0, 16'h0);
      wait_msg();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
